// File: rtl/taylor_pkg.sv
// Shared constants, FSM state type and coefficient-slice helper for the
// taylor_ln_engine series evaluator.
package taylor_pkg;

    localparam int FRAC_BITS = 15;
    localparam int COEF_W    = 16;
    localparam int N_MAX     = 8;
    localparam int ACC_W     = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Coefficient n sits at the top of the vector for n=1; out-of-range n falls back to slot 1.
    function automatic logic [COEF_W-1:0] coef_at(input logic [COEF_W*N_MAX-1:0] vec,
                                                  input logic [3:0]              n);
        int idx;
        if ((n >= 4'd1) && (n <= 4'd8)) begin
            idx = int'(n) - 1;
        end else begin
            idx = 0;
        end
        return vec[COEF_W*(N_MAX-1-idx) +: COEF_W];
    endfunction

endpackage

// File: rtl/taylor_ln_engine_if.sv
// Job handshake and result bus between a requester and taylor_ln_engine.
interface taylor_ln_engine_if;

    logic         start;
    logic [15:0]  x_in;
    logic [127:0] coeffs;
    logic         busy;
    logic         done;
    logic [17:0]  result;

    modport master (
        output start, x_in, coeffs,
        input  busy, done, result
    );

    modport slave (
        input  start, x_in, coeffs,
        output busy, done, result
    );

endinterface

// File: rtl/q15_mul.sv
// Unsigned Q1.15 x Q1.15 multiply returning the Q1.15 product.
// Define TAYLOR_ROUND_EN for round-half-up instead of truncation.
module q15_mul
    import taylor_pkg::*;
(
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    output logic [COEF_W-1:0] y
);

    logic [31:0] prod_s;
    logic        unused_prod_s;

    // Full product, optionally biased by half an LSB before the shift.
    always_comb begin
`ifdef TAYLOR_ROUND_EN
        prod_s = ({16'd0, a} * {16'd0, b}) + 32'd16384;
`else
        prod_s = {16'd0, a} * {16'd0, b};
`endif
    end

    assign y             = prod_s[FRAC_BITS +: COEF_W];
    assign unused_prod_s = ^{prod_s[31], prod_s[FRAC_BITS-1:0]};

endmodule

// File: rtl/taylor_ln_engine.sv
// Iterative ln(1+x) series evaluator, one term per clock behind start/busy/done.
// Define TAYLOR_ROUND_EN to round Q1.15 products instead of truncating.
module taylor_ln_engine
    import taylor_pkg::*;
#(
    parameter int N_TERMS = 8
) (
    input  logic                clk,
    input  logic                rst,
    taylor_ln_engine_if.slave   bus
);

    if ((N_TERMS < 1) || (N_TERMS > N_MAX)) begin : g_bad_n_terms
        $error("taylor_ln_engine: N_TERMS must be within 1..8");
    end

    localparam logic [3:0] N_LAST = 4'(N_TERMS);

    state_e                   state_q, state_d;
    logic [COEF_W-1:0]        p_q, p_d;
    logic [COEF_W-1:0]        x_q, x_d;
    logic [3:0]               n_q, n_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]         result_q, result_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [COEF_W-1:0]        coef_s;
    logic [COEF_W-1:0]        term_prod_s;
    logic [COEF_W-1:0]        pow_s;
    logic [COEF_W-1:0]        term_s;
    logic signed [ACC_W-1:0]  term_ext_s;
    logic                     unused_x_msb_s;

    assign unused_x_msb_s = bus.x_in[15];
    assign coef_s         = coef_at(bus.coeffs, n_q);

    q15_mul u_term_mul (
        .a (coef_s),
        .b (p_q),
        .y (term_prod_s)
    );

    q15_mul u_pow_mul (
        .a (p_q),
        .b (x_q),
        .y (pow_s)
    );

    // Current series term; the n=1 coefficient is implicitly 1.0.
    always_comb begin
        if (n_q == 4'd1) begin
            term_s = p_q;
        end else begin
            term_s = term_prod_s;
        end
        term_ext_s = $signed({2'b00, term_s});
    end

    // Next-state and next-output computation for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        x_d      = x_q;
        n_d      = n_q;
        acc_d    = acc_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    p_d     = {1'b0, bus.x_in[14:0]};
                    x_d     = {1'b0, bus.x_in[14:0]};
                    n_d     = 4'd1;
                    acc_d   = 18'sd0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            CALC: begin
                // Odd-numbered terms add, even-numbered terms subtract.
                if (n_q[0]) begin
                    acc_d = acc_q + term_ext_s;
                end else begin
                    acc_d = acc_q - term_ext_s;
                end
                p_d = pow_s;
                n_d = n_q + 4'd1;
                if (n_q == N_LAST) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            p_q      <= 16'd0;
            x_q      <= 16'd0;
            n_q      <= 4'd0;
            acc_q    <= 18'sd0;
            result_q <= 18'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            x_q      <= x_d;
            n_q      <= n_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_taylor_ln_engine.sv
// Scoreboard bench for taylor_ln_engine: an 8-term and a 1-term instance.
module tb_taylor_ln_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [15:0] COEF_TAB [8] = '{16'h8000, 16'h4000, 16'h2AAB, 16'h2000,
                                             16'h199A, 16'h1555, 16'h1249, 16'h1000};
    logic [127:0] coef_vec;

    taylor_ln_engine_if bus8 ();
    taylor_ln_engine_if bus1 ();

    taylor_ln_engine #(.N_TERMS(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    taylor_ln_engine #(.N_TERMS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [17:0] exp8_res [$];
    int          exp8_cyc [$];
    logic [17:0] exp1_res [$];
    int          exp1_cyc [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [15:0] mul_q15(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] pr;
        pr = {16'd0, a} * {16'd0, b};
`ifdef TAYLOR_ROUND_EN
        pr = pr + 32'd16384;
`endif
        return pr[30:15];
    endfunction

    function automatic logic [17:0] ln_model(input logic [15:0] x, input int nterms);
        logic [15:0]        xv;
        logic [15:0]        p;
        logic [15:0]        t;
        logic signed [17:0] acc;
        xv  = {1'b0, x[14:0]};
        p   = xv;
        acc = 18'sd0;
        for (int n = 1; n <= nterms; n++) begin
            t = (n == 1) ? p : mul_q15(COEF_TAB[n-1], p);
            if (n % 2 == 1) acc = acc + $signed({2'b00, t});
            else            acc = acc - $signed({2'b00, t});
            p = mul_q15(p, xv);
        end
        return acc;
    endfunction

    // Monitor for the 8-term instance: scoreboard pop, latency, busy length, hold.
    int          run8 = 0, blen8 = 0;
    logic [17:0] held8 = 18'd0;
    always @(negedge clk) begin
        if (bus8.busy && bus8.done) check_val("busy_done_overlap8", 1, 0);
        if (bus8.busy) run8++;
        else if (run8 != 0) begin blen8 = run8; run8 = 0; end
        if (rst) begin
            held8 = bus8.result;
        end else if (bus8.done) begin
            if (exp8_res.size() == 0) check_val("spurious_done8", 1, 0);
            else begin
                check_val("result8", bus8.result, exp8_res.pop_front());
                check_val("latency8", cyc, exp8_cyc.pop_front());
                check_val("busy_len8", blen8, 8);
            end
            held8 = bus8.result;
        end else if (bus8.result !== held8) begin
            check_val("hold8", bus8.result, held8);
        end
    end

    // Monitor for the 1-term instance.
    int run1 = 0, blen1 = 0;
    always @(negedge clk) begin
        if (bus1.busy) run1++;
        else if (run1 != 0) begin blen1 = run1; run1 = 0; end
        if (!rst && bus1.done) begin
            if (exp1_res.size() == 0) check_val("spurious_done1", 1, 0);
            else begin
                check_val("result1", bus1.result, exp1_res.pop_front());
                check_val("latency1", cyc, exp1_cyc.pop_front());
                check_val("busy_len1", blen1, 1);
            end
        end
    end

    // Drive one start pulse; done is due N+2 counted edges after the drive point.
    task automatic start8(input logic [15:0] x, input logic [17:0] want, input bit push);
        @(posedge clk); #1;
        bus8.start = 1'b1;
        bus8.x_in  = x;
        if (push) begin
            exp8_res.push_back(want);
            exp8_cyc.push_back(cyc + 10);
        end
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.x_in  = 16'hDEAD;
    endtask

    task automatic start1(input logic [15:0] x, input logic [17:0] want);
        @(posedge clk); #1;
        bus1.start = 1'b1;
        bus1.x_in  = x;
        exp1_res.push_back(want);
        exp1_cyc.push_back(cyc + 3);
        @(posedge clk); #1;
        bus1.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp8_res.size() != 0 || exp1_res.size() != 0); i++)
            @(posedge clk);
        if (exp8_res.size() != 0 || exp1_res.size() != 0) begin
            check_val("timeout", exp8_res.size() + exp1_res.size(), 0);
            exp8_res.delete(); exp8_cyc.delete();
            exp1_res.delete(); exp1_cyc.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    logic [17:0] half_ref;
    logic [15:0] xr;

    initial begin
        for (int i = 0; i < 8; i++) coef_vec[127-16*i -: 16] = COEF_TAB[i];
        bus8.coeffs = coef_vec;  bus1.coeffs = coef_vec;
        bus8.start  = 1'b0;      bus1.start  = 1'b0;
        bus8.x_in   = 16'd0;     bus1.x_in   = 16'd0;
`ifdef TAYLOR_ROUND_EN
        half_ref = 18'd13282;
`else
        half_ref = 18'd13280;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", bus8.busy, 0);
        check_val("rst_done", bus8.done, 0);
        check_val("rst_result", bus8.result, 0);

        start8(16'h0000, 18'h00000, 1'b1);            drain();
        start8(16'h4000, half_ref, 1'b1);             drain();
        check_val("half_model", ln_model(16'h4000, 8), half_ref);
        start8(16'hC000, half_ref, 1'b1);             drain();
        start1(16'h7FFF, 18'h07FFF);                  drain();
        start1(16'h2345, ln_model(16'h2345, 1));      drain();

        // A second start three cycles into a job must be ignored.
        start8(16'h1234, ln_model(16'h1234, 8), 1'b1);
        @(posedge clk);
        start8(16'h7000, 18'd0, 1'b0);
        drain();

        // Back-to-back jobs at the minimum start-to-start spacing.
        xr = 16'h5A5A;
        start8(xr, ln_model(xr, 8), 1'b1);
        repeat (8) @(posedge clk);
        xr = 16'h7FFF;
        start8(xr, ln_model(xr, 8), 1'b1);
        drain();

        for (int k = 0; k < 4; k++) begin
            xr = 16'($urandom);
            start8(xr, ln_model(xr, 8), 1'b1);
            drain();
        end

        // Reset mid-job: no done, cleared outputs, then a fresh job completes.
        start8(16'h3000, 18'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp8_res.delete(); exp8_cyc.delete();
        @(negedge clk); @(negedge clk);
        check_val("abort_busy", bus8.busy, 0);
        check_val("abort_result", bus8.result, 0);
        check_val("abort_done", bus8.done, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        start8(16'h3000, ln_model(16'h3000, 8), 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/taylor_ln_engine.md
# taylor_ln_engine

Iterative series evaluator that consumes the 128-bit reciprocal-coefficient vector (1, 1/2 … 1/8, Q1.15) and computes ln(1+x) = Σ (−1)^(n+1)·x^n/n for n = 1..N_TERMS.

- Sits directly downstream of the coefficient ROM, one term per clock, behind a start/busy/done handshake.
- Result is held until the next job completes.

## Interface
- N_TERMS, 8, number of series terms evaluated; legal range 1..8.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- x_in  input  16  operand x, Q1.15 unsigned; bit 15 ignored (forced 0), so 0 ≤ x < 1.
- coeffs  input  128  coefficient vector from the ROM. Coefficient n occupies bits [127−16(n−1) −: 16]. Code for n=1 is a don't-care; it is treated as 1.0.
- busy  output  1  high while terms are being evaluated.
- done  output  1  one-cycle pulse; result valid from this cycle onward.
- result  output  18  signed Q3.15 final sum.

## Operation
- **FSM states:** IDLE → CALC → DONE → IDLE.
- **IDLE:**
  - On start=1: p ← {0,x_in[14:0]}, n ← 1, acc ← 0, state ← CALC.
  - start=0: hold.
- **CALC (one term per cycle):**
  - term = n==1 ? p : trunc((coef_n·p) >> 15).
  - acc ← acc + term for odd n; acc − term for even n.
  - p ← trunc((p·x) >> 15).
  - n ← n+1.
  - When n == N_TERMS: result ← final acc, state ← DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- **start while not IDLE** is ignored; there is no queueing.
- **Arithmetic:**
  - Products are unsigned 16×16 = 32 bits, right-shifted 15, low 16 bits kept.
  - acc is signed 18-bit. No saturation is needed: partial sums stay within [0, 1).
- **Input capture:** x_in is captured at start. coeffs must be stable for the whole job; the ROM is constant.
- **Reset:**
  - Value after rst: state=IDLE, busy=0, done=0, result=0, p=0, acc=0, n=0.
  - Reset during CALC aborts the job; no done is produced.
- **Parameter checking:** N_TERMS outside 1..8 is a simulation-time error via an elaboration check.

## Timing
- Start accepted at edge E0. busy is high from E0+1 through the final CALC cycle.
- done is high in cycle E0+N_TERMS+1; result updates on that same edge.
- Default N_TERMS=8 gives done 9 cycles after the start edge. Minimum start-to-start interval is N_TERMS+2 cycles.
- busy and done are never high simultaneously.
- result is stable between done pulses.

## Configuration
- TAYLOR_ROUND_EN defined: every Q1.15 product adds 1<<14 before the >>15 (round-half-up). This applies to both the term and power products.
- TAYLOR_ROUND_EN undefined: plain truncation. This is the default and the golden model for sign-off.

## Structure
- **Package taylor_pkg holds:**
  - FRAC_BITS=15, COEF_W=16, N_MAX=8, ACC_W=18.
  - State enum {IDLE, CALC, DONE}.
  - Coefficient-slice function coef_at(vec, n).
- **Sub-module q15_mul:**
  - Unsigned 16×16 product, >>15, honours TAYLOR_ROUND_EN.
  - Instantiated twice: term product and power update.
- Top level holds only the FSM, registers and accumulator.

## Test plan
- x_in=0x0000, N_TERMS=8 → result=0x00000, done exactly 9 cycles after start, busy high 8 cycles.
- x_in=0x4000 (0.5), N_TERMS=8, truncation → terms 16384, −4096, +1365, −512, +204, −85, +36, −16; result=13280 (0x033E0).
  - Same stimulus with TAYLOR_ROUND_EN → result=13282 (0x033E2).
- x_in=0x7FFF, N_TERMS=1 → result=0x07FFF, done 2 cycles after start.
- x_in=0xC000 → bit 15 ignored; identical to the x_in=0x4000 case.
- start pulsed again 3 cycles into a job with a different x → ignored; first job's result and done timing unchanged.
- rst asserted mid-CALC (cycle 4) → next edge busy=0, result=0, no done pulse; a new start afterwards completes normally.
